// File: rtl/fb_ram_arbiter.sv
// fb_ram_arbiter: shares the single port of the frame/sprite RAM between
// the VGA pixel fetch, the game-logic/CPU port and a built-in clear engine.
// Video has fixed priority. A starvation counter bounds the CPU wait.
// Read data returns through a tag pipeline matched to the RAM latency.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   vid_*                 video read port (req/addr in; gnt/rvalid/rdata/stall out)
//   wr_*                  CPU port (req/we/addr/wdata/be in; gnt/rvalid/rdata out)
//   clr_start/clr_value   clear request pulse and fill value
//   clr_busy/clr_done     clear in progress / one-cycle completion pulse
//   ram_*                 single-port RAM command bus and read data
module fb_ram_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BE_W         = 4,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  // video read port
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_stall,
  // CPU port
  input  logic              wr_req,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic [BE_W-1:0]   wr_be,
  output logic              wr_gnt,
  output logic              wr_rvalid,
  output logic [DATA_W-1:0] wr_rdata,
  // clear engine control
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  // RAM side
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  output logic [BE_W-1:0]   ram_byteena,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_WR  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              clr_done_q, clr_done_d;

  // Tag pipeline: bit RD_LAT-1 lines up with ram_q for the matching read.
  logic [RD_LAT-1:0] tag_valid_q, tag_owner_q;
  logic              push_valid, push_owner;

  logic [DATA_W-1:0] vid_rdata_q, wr_rdata_q;

  // Arbitration, RAM command and next-state logic.
  // Nothing is granted while reset is held, so the RAM sees an idle bus.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_val_d   = clr_val_q;
    starve_d    = starve_q;
    clr_done_d  = 1'b0;
    vid_gnt     = 1'b0;
    wr_gnt      = 1'b0;
    vid_stall   = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    ram_byteena = '0;
    push_valid  = 1'b0;
    push_owner  = OWN_VID;

    if (Reset_n) begin
      case (state_q)
        ST_ARB: begin
          if (vid_req && (starve_q < STARVE_MAX)) begin
            vid_gnt = 1'b1;
          end else if (wr_req) begin
            wr_gnt    = 1'b1;
            // Only reachable with video pending when the CPU is overriding it.
            vid_stall = vid_req;
          end

          if (vid_gnt) begin
            ram_address = vid_addr;
            ram_rden    = 1'b1;
            push_valid  = 1'b1;
            push_owner  = OWN_VID;
          end

          if (wr_gnt) begin
            ram_address = wr_addr;
            push_owner  = OWN_WR;
            if (wr_we) begin
              ram_wren    = 1'b1;
              ram_data    = wr_wdata;
              ram_byteena = wr_be;
            end else begin
              ram_rden   = 1'b1;
              push_valid = 1'b1;
            end
          end

          // Count consecutive denied cycles, saturating at the limit.
          if (wr_req && !wr_gnt) begin
            if (starve_q != STARVE_MAX) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end else begin
            starve_d = '0;
          end

          if (clr_start) begin
            state_d    = ST_CLEAR;
            clr_val_d  = clr_value;
            clr_addr_d = '0;
          end
        end

        ST_CLEAR: begin
          // Video always goes ahead of the clear; the CPU waits it out.
          if (vid_req) begin
            vid_gnt     = 1'b1;
            ram_address = vid_addr;
            ram_rden    = 1'b1;
            push_valid  = 1'b1;
            push_owner  = OWN_VID;
          end else begin
            ram_address = clr_addr_q;
            ram_data    = clr_val_q;
            ram_wren    = 1'b1;
            ram_byteena = '1;
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
              state_d    = ST_ARB;
              clr_done_d = 1'b1;
            end
          end
        end

        default: state_d = ST_ARB;
      endcase
    end
  end

  // State, clear engine, starvation counter and read-return registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_ARB;
      clr_addr_q  <= '0;
      clr_val_q   <= '0;
      starve_q    <= '0;
      clr_done_q  <= 1'b0;
      tag_valid_q <= '0;
      tag_owner_q <= '0;
      vid_rdata_q <= '0;
      wr_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_val_q   <= clr_val_d;
      starve_q    <= starve_d;
      clr_done_q  <= clr_done_d;
      tag_valid_q <= (tag_valid_q << 1) | RD_LAT'(push_valid);
      tag_owner_q <= (tag_owner_q << 1) | RD_LAT'(push_owner);
      if (vid_rvalid) begin
        vid_rdata_q <= ram_q;
      end
      if (wr_rvalid) begin
        wr_rdata_q <= ram_q;
      end
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;

  // Return stage: ram_q is steered to the owning port; rdata holds otherwise.
  assign vid_rvalid = tag_valid_q[RD_LAT-1] & (tag_owner_q[RD_LAT-1] == OWN_VID);
  assign wr_rvalid  = tag_valid_q[RD_LAT-1] & (tag_owner_q[RD_LAT-1] == OWN_WR);
  assign vid_rdata  = vid_rvalid ? ram_q : vid_rdata_q;
  assign wr_rdata   = wr_rvalid  ? ram_q : wr_rdata_q;

endmodule

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Shares the single port of the on-chip frame/sprite RAM between three users: the VGA pixel fetch, the game-logic/CPU access port, and an internal clear engine.
- Video has fixed priority. A starvation counter gives the CPU port a bounded wait.
- Read data returns through a tag pipeline that matches the RAM latency.
- Sits between vga_controller/color_mapper and the RAM instance in the top level.

Parameters:
- ADDR_W, 10, RAM address width; the RAM holds 2**ADDR_W words.
- DATA_W, 32, RAM word width.
- BE_W, 4, byte-enable width (DATA_W/8).
- RD_LAT, 2, cycles from read grant edge to valid ram_q (≥1).
- STARVE_LIMIT, 8, consecutive denied cycles before the CPU port is forced through over video.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DATA_W  video read data
- vid_stall  out  1  vid_req denied this cycle (starvation override)
- wr_req  in  1  CPU port request
- wr_we  in  1  1 = write, 0 = read
- wr_addr  in  ADDR_W  CPU address
- wr_wdata  in  DATA_W  CPU write data
- wr_be  in  BE_W  CPU byte enables
- wr_gnt  out  1  CPU request accepted this cycle
- wr_rvalid  out  1  CPU read data valid
- wr_rdata  out  DATA_W  CPU read data
- clr_start  in  1  one-cycle pulse: begin clear
- clr_value  in  DATA_W  fill value, sampled on clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- ram_address  out  ADDR_W  to RAM
- ram_data  out  DATA_W  to RAM
- ram_wren  out  1  to RAM
- ram_rden  out  1  to RAM
- ram_byteena  out  BE_W  to RAM
- ram_q  in  DATA_W  from RAM

Behaviour:
- Reset (async, Reset_n=0):
  - FSM goes to ARB; clear address, starve counter and tag pipeline go to 0.
  - All gnt, rvalid, clr_busy, clr_done and vid_stall are 0.
  - ram_wren=ram_rden=0, ram_byteena=0.
  - An in-flight clear is abandoned. Pending read tags are dropped, so no rvalid appears after reset.
- Handshake:
  - The requester holds req and its address/data stable until gnt=1.
  - gnt is combinational in the cycle the RAM command is driven. The RAM samples at the next rising edge.
  - At most one gnt per cycle. Unused cycles drive ram_wren=ram_rden=0.
- Arbitration, FSM state ARB:
  - If vid_req and starve_cnt<STARVE_LIMIT: video wins.
  - Else if wr_req: CPU wins.
  - Else idle.
  - If wr_req and starve_cnt==STARVE_LIMIT: the CPU wins; vid_stall=1 if vid_req.
- starve_cnt:
  - Increments each cycle wr_req=1 and wr_gnt=0, saturating at STARVE_LIMIT.
  - Clears on wr_gnt or wr_req=0.
- FSM state CLEAR, entered on clr_start in ARB:
  - Latches clr_value; clr_busy=1 from the next cycle.
  - Each cycle without vid_req: write clr_value with byteena all-1 to clr_addr, then clr_addr+1.
  - Video is always served ahead of clear.
  - wr_gnt=0 throughout and starve_cnt is held (no override during clear).
  - After writing address 2**ADDR_W−1: clr_done=1 for one cycle, clr_busy=0, return to ARB. clr_addr wraps to 0.
  - clr_start while busy is ignored.
  - clr_start in the same cycle as a CPU grant: the CPU access completes that cycle and CLEAR starts the next.
- Read return:
  - Each read grant pushes {valid=1, owner} into an RD_LAT-deep shift register. Writes push valid=0.
  - At the output stage, the owner's rvalid=1 for one cycle and its rdata=ram_q. The other port's rvalid=0.
  - rdata holds its last value when not valid.
  - Back-to-back reads are supported at one per cycle. Latency is exactly RD_LAT cycles after the gnt cycle's edge.
- Writes: ram_data=wr_wdata, ram_byteena=wr_be, ram_wren=1. No response; a write is complete at the gnt edge.

Test Plan:
- Video reads of addrs 0..3 back-to-back, RD_LAT=2 → vid_gnt 4 consecutive cycles; vid_rvalid on cycles +2..+5 with data of addrs 0..3; wr_rvalid stays 0.
- CPU write 0xDEADBEEF to addr 5 with be=4'b0011 over old 0x11223344, then CPU read addr 5 → wr_rdata=0x1122BEEF.
- vid_req held high continuously with wr_req high → wr_gnt on the 9th cycle (STARVE_LIMIT=8) with vid_stall=1 that cycle; video resumes the next cycle.
- clr_start with value 0x0, no video traffic → clr_busy for 1024 cycles, clr_done pulse once; all addrs read 0. With video every other cycle, the clear takes ≈2048 cycles and wr_req stays ungranted until clr_done.
- Reset_n pulsed low mid-clear with two reads in flight → outputs 0 immediately; no rvalid after release; next clr_start restarts from addr 0.
